// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
// Bundles the instruction-memory port and the instruction issue handshake.
// master: the sequencer (drives address, write strobe/data and the issued instruction).
// slave : the memory/datapath side (returns read data and the accept signal).
interface fetch_sequencer_if;
    logic [2:0]  im_add;
    logic        im_wr_en;
    logic [11:0] im_wr_data;
    logic [11:0] im_rd;
    logic [11:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output im_add,
        output im_wr_en,
        output im_wr_data,
        output instr,
        output instr_valid,
        input  im_rd,
        input  instr_ready
    );

    modport slave (
        input  im_add,
        input  im_wr_en,
        input  im_wr_data,
        input  instr,
        input  instr_valid,
        output im_rd,
        output instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Loads up to eight 12-bit words into a small instruction memory from the
// switches, then fetches them back one at a time and issues them to the
// datapath, either continuously (run) or one instruction per step press.
// An instruction whose top three bits are 000 is a HALT and ends a run.
//
// Optional feature macro: FETCH_LOOP_EN
//   defined   : a run that accepts the instruction at pc=7 wraps to pc=0 and
//               keeps fetching.
//   undefined : a run that accepts the instruction at pc=7 stops in DONE
//               with pc=0. Step mode always wraps 7 -> 0.
//
// Issue handshake: instr_valid is high for the whole ISSUE state and instr is
// held constant while it is high; a transfer happens on a rising CLK edge
// where instr_valid and instr_ready are both 1 (and halt_btn/reset are not
// asserted). instr_valid drops on that same edge. instr_ready may be high at
// any time without effect when instr_valid is low.
//
// Memory timing: im_add is combinational from registered state, the memory
// returns im_rd one cycle later, so FETCH presents the address and CAPTURE
// samples the data.
module fetch_sequencer (
    input  logic              CLK,
    input  logic              reset,
    input  logic [11:0]       switchesData,
    input  logic              load_btn,
    input  logic              run_btn,
    input  logic              step_btn,
    input  logic              halt_btn,
    fetch_sequencer_if.master bus,
    output logic [2:0]        pc,
    output logic [3:0]        load_count,
    output logic              done,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        ISSUE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  pc_q, pc_d;
    logic [3:0]  load_count_q, load_count_d;
    logic        run_mode_q, run_mode_d;   // 1: run, 0: single step
    logic        wr_en_q, wr_en_d;
    logic [2:0]  wr_addr_q, wr_addr_d;
    logic [11:0] wr_data_q, wr_data_d;
    logic [11:0] instr_q, instr_d;

    // State and datapath registers; reset overrides every other input.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= 3'd0;
            load_count_q <= 4'd0;
            run_mode_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 3'd0;
            wr_data_q    <= 12'd0;
            instr_q      <= 12'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            load_count_q <= load_count_d;
            run_mode_q   <= run_mode_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            instr_q      <= instr_d;
        end
    end

    // Next-state and next-value decode for every register.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        load_count_d = load_count_q;
        run_mode_d   = run_mode_q;
        wr_en_d      = 1'b0;            // the write strobe only ever lasts one cycle
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        instr_d      = instr_q;

        case (state_q)
            IDLE: begin
                // run beats step beats load; losers of the same cycle are dropped
                if (run_btn) begin
                    pc_d         = 3'd0;
                    load_count_d = 4'd0;
                    run_mode_d   = 1'b1;
                    state_d      = FETCH;
                end else if (step_btn) begin
                    run_mode_d   = 1'b0;
                    state_d      = FETCH;
                end else if (load_btn && !load_count_q[3]) begin
                    // load_count[3] set means all eight words are filled
                    wr_en_d      = 1'b1;
                    wr_addr_d    = load_count_q[2:0];
                    wr_data_d    = switchesData;
                    load_count_d = load_count_q + 4'd1;
                end
            end

            FETCH: begin
                if (halt_btn) begin
                    state_d = IDLE;
                end else begin
                    state_d = CAPTURE;
                end
            end

            CAPTURE: begin
                if (halt_btn) begin
                    state_d = IDLE;
                end else begin
                    instr_d = bus.im_rd;
                    if (bus.im_rd[11:9] == 3'b000) begin
                        state_d = DONE;     // HALT word is never issued
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end

            ISSUE: begin
                // halt wins over a same-cycle accept: nothing is transferred
                if (halt_btn) begin
                    state_d = IDLE;
                end else if (bus.instr_ready) begin
                    pc_d = pc_q + 3'd1;     // 3-bit pc wraps 7 -> 0 on its own
                    if (!run_mode_q) begin
                        state_d = IDLE;
                    end else if (pc_q == 3'd7) begin
`ifdef FETCH_LOOP_EN
                        state_d = FETCH;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = FETCH;
                    end
                end
            end

            DONE: begin
                if (run_btn) begin
                    pc_d       = 3'd0;
                    run_mode_d = 1'b1;
                    state_d    = FETCH;
                end else if (halt_btn) begin
                    state_d = IDLE;
                end
            end

            default: begin
                // unused encodings recover to IDLE
                state_d = IDLE;
            end
        endcase
    end

    // The single address bus serves the fetch read and the load write.
    assign bus.im_add      = (state_q == FETCH) ? pc_q :
                             (wr_en_q ? wr_addr_q : 3'd0);
    assign bus.im_wr_en    = wr_en_q;
    assign bus.im_wr_data  = wr_data_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state_q == ISSUE);

    assign pc         = pc_q;
    assign load_count = load_count_q;
    assign done       = (state_q == DONE);
    assign state      = state_q;

endmodule
